des_round_ctrl: RTL and testbench
=================================

Name: des_round_ctrl

Overview:
- Sequencing controller for the LFSR-integrated DES Feistel datapath.
- Accepts a block-start request and drives the L/R register load/feedback select, the per-round enable, the round and subkey indices, and LFSR stepping.
- Pulses the output-register load after the final round.
- Sits between the host/top-level handshake and the Feistel round logic plus final output register.

Parameters:
- NUM_ROUNDS, 16, number of Feistel rounds per block (legal 2..16).
- ROUND_W, 4, width of round/key index; must satisfy 2^ROUND_W >= NUM_ROUNDS.
- CNT_W, 16, width of completed-block counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to process the block currently on the datapath input
- mode  input  1  0 = encrypt, 1 = decrypt; sampled only when a start is accepted
- abort  input  1  synchronous cancel of the block in flight
- ready  output  1  controller idle, start will be accepted
- busy  output  1  block in flight (LOAD, ROUND or FINAL)
- in_sel  output  1  1 = L/R registers take the external input; 0 = round feedback
- round_en  output  1  L/R registers update this cycle
- round_idx  output  ROUND_W  current round number, 0..NUM_ROUNDS-1
- key_idx  output  ROUND_W  subkey select: round_idx (encrypt), NUM_ROUNDS-1-round_idx (decrypt)
- lfsr_step  output  1  advance round-key LFSR one step
- out_load  output  1  load strobe to final output register (performs final swap)
- done  output  1  one-cycle completion pulse, coincident with out_load
- blk_cnt  output  CNT_W  number of blocks completed since reset

Behaviour:
- Reset: synchronous. When rst is high at a clock edge, the next state is:
  - state = IDLE, round counter = 0, latched mode = 0, blk_cnt = 0;
  - ready = 1, all other 1-bit outputs = 0, round_idx = key_idx = 0.
  - rst overrides start and abort.
- Output decoding: Moore style; all outputs are decoded from registered state/counter only, with no combinational path from start/abort/mode.
- States and transitions:
  - IDLE: ready = 1. start=1 at an edge -> LOAD; latch mode.
  - LOAD (1 cycle): in_sel = 1, round_en = 1, lfsr_step = 0; round counter cleared to 0 -> ROUND.
  - ROUND (NUM_ROUNDS cycles): in_sel = 0, round_en = 1, lfsr_step = 1. round_idx = counter; counter increments each cycle. At counter = NUM_ROUNDS-1 -> FINAL.
  - FINAL (1 cycle): out_load = 1, done = 1, round_en = 0; blk_cnt increments at the end of the cycle -> IDLE.
- busy = 1 in LOAD, ROUND and FINAL. ready = !busy.
- Latency: if start is accepted in cycle 0, then:
  - LOAD occurs in cycle 1;
  - rounds 0..NUM_ROUNDS-1 occur in cycles 2..NUM_ROUNDS+1;
  - out_load/done occur in cycle NUM_ROUNDS+2 (18 for the default);
  - ready returns in cycle NUM_ROUNDS+3;
  - the output register's valid appears one cycle after out_load.
- Throughput: one block per NUM_ROUNDS+3 cycles. No back-to-back acceptance in FINAL.
- start while busy: ignored, not queued. mode changes while busy have no effect.
- key_idx: uses the mode latched at acceptance. It is held at 0 outside ROUND.
- abort:
  - In LOAD or ROUND: next state IDLE, counter cleared, no out_load, no done, blk_cnt unchanged.
  - In FINAL: ignored; the block completes.
  - In IDLE: no effect, and blocks acceptance of a simultaneous start (abort has priority).
- blk_cnt: wraps modulo 2^CNT_W with no saturation.
- Counter never exceeds NUM_ROUNDS-1. Any unreachable state encoding recovers to IDLE on the next clock.

Test Plan:
- Reset then idle: rst high 2 cycles, start=0 -> ready=1, busy=0, out_load=0, blk_cnt=0 for 10 cycles.
- Encrypt block: start=1, mode=0 in cycle 0 -> in_sel=1 in cycle 1; round_idx=key_idx=0..15 in cycles 2..17 with lfsr_step=1; out_load=done=1 only in cycle 18; ready=1 in cycle 19; blk_cnt=1. A bench-side Output_reg's valid is high in cycle 19.
- Decrypt block: start with mode=1, mode toggled during rounds -> key_idx=15..0 while round_idx=0..15; done at cycle 18.
- Start while busy: pulse start at cycles 5 and 18 of a block -> both ignored, exactly one done; a start in cycle 19 is accepted with done in cycle 37.
- Abort: abort=1 in cycle 9 (round 7) -> IDLE/ready in cycle 10, no out_load, blk_cnt unchanged. abort in FINAL -> done still asserted. Simultaneous start+abort in IDLE -> not accepted.
- Reset mid-block: rst=1 in cycle 12 -> ready=1, round_idx=0 next cycle, no done. blk_cnt wrap with CNT_W=2: 5 blocks -> blk_cnt=1.

Source files
------------

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencing controller for the LFSR-integrated DES Feistel
// datapath. A start request loads the L/R registers from the external input,
// then steps through NUM_ROUNDS Feistel rounds (advancing the round-key LFSR
// each round), and finally strobes the output register, which performs the
// final swap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      block-start request, accepted only in IDLE
//   mode       0 = encrypt, 1 = decrypt; latched when start is accepted
//   abort      cancels a block in LOAD or ROUND; ignored in FINAL
//   ready      idle, start will be accepted
//   busy       block in flight (LOAD, ROUND, FINAL)
//   in_sel     1 = L/R take external input, 0 = round feedback
//   round_en   L/R registers update this cycle
//   round_idx  current round number (0 outside ROUND)
//   key_idx    subkey select, reversed for decrypt (0 outside ROUND)
//   lfsr_step  advance round-key LFSR
//   out_load   final output register load strobe
//   done       one-cycle completion pulse, coincident with out_load
//   blk_cnt    completed blocks since reset, wraps
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int ROUND_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  output logic               ready,
  output logic               busy,
  output logic               in_sel,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic [ROUND_W-1:0] key_idx,
  output logic               lfsr_step,
  output logic               out_load,
  output logic               done,
  output logic [CNT_W-1:0]   blk_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state, state_nxt;
  logic [ROUND_W-1:0] cnt, cnt_nxt;
  logic               mode_q, mode_nxt;
  logic [CNT_W-1:0]   blk_q, blk_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      blk_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      blk_q  <= blk_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    blk_nxt   = blk_q;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        // abort in IDLE suppresses a simultaneous start
        if (start && !abort) begin
          state_nxt = S_LOAD;
          mode_nxt  = mode;
        end
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = abort ? S_IDLE : S_ROUND;
      end
      S_ROUND: begin
        if (abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= LAST_RND) begin
          // >= keeps the counter bounded even from a corrupted value
          state_nxt = S_FINAL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_FINAL: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        blk_nxt   = blk_q + 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore output decode: registered state only
  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    in_sel    = 1'b0;
    round_en  = 1'b0;
    round_idx = '0;
    key_idx   = '0;
    lfsr_step = 1'b0;
    out_load  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_LOAD: begin
        busy     = 1'b1;
        in_sel   = 1'b1;
        round_en = 1'b1;
      end
      S_ROUND: begin
        busy      = 1'b1;
        round_en  = 1'b1;
        lfsr_step = 1'b1;
        round_idx = cnt;
        key_idx   = mode_q ? (LAST_RND - cnt) : cnt;
      end
      S_FINAL: begin
        busy     = 1'b1;
        out_load = 1'b1;
        done     = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  assign blk_cnt = blk_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst, start, mode, abort;

  logic       ready, busy, in_sel, round_en, lfsr_step, out_load, done;
  logic [3:0] round_idx, key_idx;
  logic [15:0] blk_cnt;

  logic       ready2, busy2, in_sel2, round_en2, lfsr_step2, out_load2, done2;
  logic [3:0] round_idx2, key_idx2;
  logic [1:0] blk_cnt2;

  always #5 clk = ~clk;

  des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .ready(ready), .busy(busy), .in_sel(in_sel), .round_en(round_en),
    .round_idx(round_idx), .key_idx(key_idx), .lfsr_step(lfsr_step),
    .out_load(out_load), .done(done), .blk_cnt(blk_cnt)
  );

  // Narrow block counter instance for the wrap check
  des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .ready(ready2), .busy(busy2), .in_sel(in_sel2), .round_en(round_en2),
    .round_idx(round_idx2), .key_idx(key_idx2), .lfsr_step(lfsr_step2),
    .out_load(out_load2), .done(done2), .blk_cnt(blk_cnt2)
  );

  // Bench-side output register valid
  logic ovld;
  always_ff @(posedge clk) begin
    if (rst) ovld <= 1'b0;
    else     ovld <= out_load;
  end

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       in_sel;
    logic       round_en;
    logic [3:0] ridx;
    logic [3:0] kidx;
    logic       lfsr;
    logic       out_load;
    logic       done;
    logic       ovld;
    logic [15:0] blk;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;

  function automatic exp_t idle_e(int blk);
    exp_t e = '0;
    e.ready = 1'b1;
    e.blk   = 16'(blk);
    return e;
  endfunction

  // Expected outputs c cycles after a start accepted in cycle 0.
  // ab = cycle in which abort is held (-1 for none).
  function automatic exp_t exp_blk(int c, bit m, int blk, int ab);
    exp_t e;
    bit aborted = (ab >= 1) && (ab <= 17);
    if (c <= 0 || (aborted && c > ab)) return idle_e(blk);
    e = '0;
    e.blk = 16'(blk);
    if (c == 1) begin
      e.busy = 1'b1; e.in_sel = 1'b1; e.round_en = 1'b1;
    end else if (c <= 17) begin
      e.busy = 1'b1; e.round_en = 1'b1; e.lfsr = 1'b1;
      e.ridx = 4'(c - 2);
      e.kidx = m ? 4'(15 - (c - 2)) : 4'(c - 2);
    end else if (c == 18) begin
      e.busy = 1'b1; e.out_load = 1'b1; e.done = 1'b1;
    end else begin
      e = idle_e(blk + 1);
      e.ovld = (c == 19);
    end
    return e;
  endfunction

  task automatic push(string n, exp_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expectation per cycle, compare on the falling edge
  always @(negedge clk) begin
    exp_t  e, a, e2, a2;
    string n;
    if (done) done_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {ready, busy, in_sel, round_en, round_idx, key_idx, lfsr_step,
           out_load, done, ovld, blk_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s t=%0t: got %h want %h", n, $time, a, e);
      end
      e2 = e;
      e2.blk = {14'd0, e.blk[1:0]};
      e2.ovld = 1'b0;
      a2 = {ready2, busy2, in_sel2, round_en2, round_idx2, key_idx2, lfsr_step2,
            out_load2, done2, 1'b0, 14'd0, blk_cnt2};
      total++;
      if (a2 !== e2) begin
        bad++;
        $display("FAIL %s_cnt2 t=%0t: got %h want %h", n, $time, a2, e2);
      end
    end
  end

  typedef struct {
    string name;
    bit    mode;
    int    ab;
    int    p1;
    int    p2;
    bit    tog;
    int    exp_done;
  } sc_t;

  initial begin
    sc_t tbl[6];
    int  blk;
    int  d0;

    tbl[0] = '{name: "enc",         mode: 1'b0, ab: -1, p1: -1, p2: -1, tog: 1'b0, exp_done: 1};
    tbl[1] = '{name: "dec_toggle",  mode: 1'b1, ab: -1, p1: -1, p2: -1, tog: 1'b1, exp_done: 1};
    tbl[2] = '{name: "start_busy",  mode: 1'b0, ab: -1, p1: 5,  p2: 18, tog: 1'b0, exp_done: 1};
    tbl[3] = '{name: "abort_r7",    mode: 1'b0, ab: 9,  p1: -1, p2: -1, tog: 1'b0, exp_done: 0};
    tbl[4] = '{name: "abort_final", mode: 1'b1, ab: 18, p1: -1, p2: -1, tog: 1'b0, exp_done: 1};
    tbl[5] = '{name: "abort_load",  mode: 1'b0, ab: 1,  p1: -1, p2: -1, tog: 1'b0, exp_done: 0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    blk = 0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      push("idle_rst", idle_e(0));
      step();
    end

    // Table-driven single-block scenarios
    for (int s = 0; s < 6; s++) begin
      d0 = done_seen;
      for (int c = 0; c <= 20; c++) begin
        start = (c == 0) || (c == tbl[s].p1) || (c == tbl[s].p2);
        abort = (c == tbl[s].ab);
        if (c == 0)          mode = tbl[s].mode;
        else if (tbl[s].tog) mode = ~mode;
        push(tbl[s].name, exp_blk(c, tbl[s].mode, blk, tbl[s].ab));
        step();
      end
      start = 1'b0; abort = 1'b0;
      total++;
      if (done_seen - d0 != tbl[s].exp_done) begin
        bad++;
        $display("FAIL %s_done_count: got %0d want %0d", tbl[s].name,
                 done_seen - d0, tbl[s].exp_done);
      end
      blk += tbl[s].exp_done;
    end

    // Simultaneous start and abort in IDLE: not accepted
    for (int c = 0; c < 4; c++) begin
      start = (c == 0); abort = (c == 0);
      push("start_abort_idle", idle_e(blk));
      step();
    end
    start = 1'b0; abort = 1'b0;

    // Start in the cycle ready returns is accepted back-to-back
    for (int c = 0; c <= 38; c++) begin
      exp_t e;
      start = (c == 0) || (c == 19);
      mode  = 1'b0;
      if (c < 19) e = exp_blk(c, 1'b0, blk, -1);
      else        e = exp_blk(c - 19, 1'b0, blk + 1, -1);
      if (c == 19) e.ovld = 1'b1;
      push("back_to_back", e);
      step();
    end
    start = 1'b0;
    blk += 2;

    // Reset in the middle of a block
    d0 = done_seen;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      rst   = (c == 12);
      push("rst_mid", (c <= 12) ? exp_blk(c, 1'b0, blk, -1) : idle_e(0));
      step();
    end
    start = 1'b0; rst = 1'b0;
    blk = 0;
    total++;
    if (done_seen != d0) begin
      bad++;
      $display("FAIL rst_mid_done: got %0d pulses want 0", done_seen - d0);
    end

    // Five blocks: narrow counter wraps to 1
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c <= 20; c++) begin
        start = (c == 0);
        mode  = b[0];
        push("wrap", exp_blk(c, b[0], blk, -1));
        step();
      end
      start = 1'b0;
      blk++;
    end
    total++;
    if (blk_cnt2 !== 2'd1) begin
      bad++;
      $display("FAIL wrap_cnt2: got %0d want 1", blk_cnt2);
    end
    total++;
    if (blk_cnt !== 16'd5) begin
      bad++;
      $display("FAIL wrap_cnt16: got %0d want 5", blk_cnt);
    end

    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
